// File: rtl/temporal_encoder_pkg.sv
// rtl/temporal_encoder_pkg.sv - shared types and defaults for the temporal encoder
//
// Purpose:
//   Holds the encoder FSM state enum, the default parameter values and the
//   spike-time type shared by temporal_encoder and its gamma counter.
//   NUM_IN_DEF matches the neuron's spikes_in width (num_spikes).
//   TBITS_DEF sets the gamma window to 2**TBITS_DEF cycles.

package temporal_encoder_pkg;

  localparam int NUM_IN_DEF = 4;
  localparam int TBITS_DEF  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  typedef logic [TBITS_DEF-1:0] spike_time_t;

endpackage

// File: rtl/temporal_encoder_gamma_counter.sv
// rtl/temporal_encoder_gamma_counter.sv - time-step counter for one gamma window
//
// Purpose:
//   Counts the time step inside a gamma window of 2**TBITS cycles. The count
//   is restarted by a window start or a flush. While the window runs it
//   advances once per cycle and returns to zero after the final step.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   i_start  in   a new window starts at this edge (count -> 0)
//   i_flush  in   abort the current window (count -> 0), wins over everything
//   i_run    in   window in progress, advance the count
//   o_t_now  out  current time step (registered)
//   o_last   out  high while running on the final step (t == 2**TBITS-1)

module temporal_encoder_gamma_counter
  import temporal_encoder_pkg::*;
#(
  parameter int TBITS = TBITS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_flush,
  input  logic             i_run,
  output logic [TBITS-1:0] o_t_now,
  output logic             o_last
);

  localparam logic [TBITS-1:0] T_LAST = '1;

  logic [TBITS-1:0] r_t;
  logic             w_last;

  // The final-step exit keeps the count from ever wrapping inside a window.
  assign w_last  = i_run && (r_t == T_LAST);
  assign o_last  = w_last;
  assign o_t_now = r_t;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t <= '0;
    end else if (i_flush || i_start) begin
      r_t <= '0;
    end else if (i_run) begin
      r_t <= w_last ? '0 : r_t + TBITS'(1);
    end
  end

endmodule

// File: rtl/temporal_encoder.sv
// rtl/temporal_encoder.sv - step-coded spike train generator feeding the neuron
//
// Purpose:
//   Accepts one vector of per-line spike times per gamma window and plays it
//   out as a step code: a line rises in the cycle where t_now equals its
//   time and stays high until the window ends, so the downstream neuron sees
//   a monotonically growing spike vector. A one-cycle done pulse follows the
//   window. flush aborts a window without a done pulse.
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   in_valid      in   input vector valid
//   in_ready      out  encoder can accept a vector (IDLE and no flush)
//   in_times      in   NUM_IN x TBITS spike time per line (0 = earliest)
//   in_mask       in   1 = line fires this window, 0 = line silent
//   flush         in   synchronous abort of the current window
//   spikes_out    out  step-coded spikes, to neuron spikes_in
//   gamma_active  out  spikes_out holds a valid window sample
//   t_now         out  current time step within the window
//   gamma_done    out  one-cycle pulse at window end

module temporal_encoder
  import temporal_encoder_pkg::*;
#(
  parameter int NUM_IN = NUM_IN_DEF,
  parameter int TBITS  = TBITS_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_IN-1:0][TBITS-1:0] in_times,
  input  logic [NUM_IN-1:0]            in_mask,
  input  logic                         flush,
  output logic [NUM_IN-1:0]            spikes_out,
  output logic                         gamma_active,
  output logic [TBITS-1:0]             t_now,
  output logic                         gamma_done
);

  state_t                      r_state;
  state_t                      w_next_state;
  logic [NUM_IN-1:0][TBITS-1:0] r_times;
  logic [NUM_IN-1:0]           r_mask;
  logic [NUM_IN-1:0]           r_spikes;
  logic                        r_active;
  logic                        r_done;

  logic                        w_accept;
  logic                        w_run;
  logic                        w_last;
  logic [TBITS-1:0]            w_t_now;
  logic [TBITS-1:0]            w_t_next;
  logic [NUM_IN-1:0]           w_first;
  logic [NUM_IN-1:0]           w_hit;

  // Flush blocks acceptance in the same cycle it aborts a window.
  assign in_ready = (r_state == ST_IDLE) && !flush;
  assign w_accept = in_valid && in_ready;
  assign w_run    = (r_state == ST_RUN);

  temporal_encoder_gamma_counter #(
    .TBITS (TBITS)
  ) u_gamma_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_accept),
    .i_flush (flush),
    .i_run   (w_run),
    .o_t_now (w_t_now),
    .o_last  (w_last)
  );

  // Lines are evaluated one step ahead so each one is visible in the very
  // cycle where t_now equals its time.
  assign w_t_next = w_t_now + TBITS'(1);

  always_comb begin
    w_first = '0;
    w_hit   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_first[i] = in_mask[i] && (in_times[i] == '0);
      w_hit[i]   = r_mask[i] && (r_times[i] == w_t_next);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_accept) w_next_state = ST_RUN;
        ST_RUN:   if (w_last)   w_next_state = ST_CLEAR;
        ST_CLEAR: w_next_state = ST_IDLE;
        default:  w_next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_times  <= '0;
      r_mask   <= '0;
      r_spikes <= '0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else if (flush) begin
      r_spikes <= '0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_times  <= in_times;
            r_mask   <= in_mask;
            r_spikes <= w_first;
            r_active <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_last) begin
            r_spikes <= '0;
            r_active <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            // OR-accumulate: a line never falls while the window runs.
            r_spikes <= r_spikes | w_hit;
          end
        end
        ST_CLEAR: begin
          r_done <= 1'b0;
        end
        default: begin
          r_spikes <= '0;
          r_active <= 1'b0;
          r_done   <= 1'b0;
        end
      endcase
    end
  end

  assign spikes_out   = r_spikes;
  assign gamma_active = r_active;
  assign gamma_done   = r_done;
  assign t_now        = w_t_now;

endmodule

// File: doc/temporal_encoder.md
Name: temporal_encoder

Overview:
- Upstream stage of `neuron`. Converts one vector of per-line spike times into a step-coded spike train across a gamma window of 2**TBITS cycles.
- Once a line fires, it stays high until the window ends. The purely combinational neuron therefore sees a monotonically growing `spikes_in` and behaves as a temporal accumulator.
- A valid/ready handshake on the input side takes one vector per window. A one-cycle done pulse marks each window end.

Parameters:
- NUM_IN, default `num_spikes: number of spike lines; equals the neuron's spikes_in width.
- TBITS, default 3: spike-time width; window length T = 2**TBITS cycles (8).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input vector valid
- in_ready  out  1  encoder can accept a vector
- in_times  in  NUM_IN x TBITS  spike time per line (0 = earliest)
- in_mask  in  NUM_IN  1 = line fires this window; 0 = line silent
- flush  in  1  synchronous abort of the current window
- spikes_out  out  NUM_IN  step-coded spikes, connects to neuron spikes_in
- gamma_active  out  1  high while spikes_out is a valid window sample
- t_now  out  TBITS  current time step within the window
- gamma_done  out  1  one-cycle pulse at window end

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, spikes_out=0, t_now=0, gamma_active=0, gamma_done=0, latched times/mask=0.
- Outputs are registered. in_ready is combinational: (state==IDLE) && !flush.
- States:
  - IDLE: wait for a vector.
  - RUN: window in progress.
  - CLEAR: one cycle, window ending.
- IDLE -> RUN on an edge with in_valid && in_ready.
  - Latch in_times and in_mask.
  - t_now<=0, gamma_active<=1.
  - spikes_out[i] <= in_mask[i] && (in_times[i]==0).
- RUN, t_now<T-1, each edge:
  - t_now<=t_now+1.
  - spikes_out[i] <= spikes_out[i] | (mask[i] && time[i]==t_now+1).
  - A bit never falls during RUN.
- RUN, t_now==T-1, edge: state<=CLEAR, spikes_out<=0, gamma_active<=0, gamma_done<=1, t_now<=0.
- CLEAR, edge: state<=IDLE, gamma_done<=0.
- Timing consequences:
  - Window is exactly T cycles of gamma_active.
  - A line with time k first appears in the cycle where t_now==k.
  - Minimum acceptance spacing is T+2 cycles.
- Masked-off lines stay 0 for the whole window, whatever their time.
- A line with time T-1 is high only in the final RUN cycle.
- t_now is compared as unsigned TBITS. It must not wrap inside a window; the exit at T-1 guarantees this.
- flush high at an edge, in any state:
  - state<=IDLE, spikes_out<=0, gamma_active<=0, t_now<=0, gamma_done<=0.
  - No done pulse is produced.
  - Flush takes priority over acceptance: in_ready is low while flush is high, so no vector is taken that cycle.
- in_valid while not in IDLE: ignored. The source must hold the vector until in_ready.
- Reset asserted mid-window: immediate return to the reset values above. No done pulse.

Decomposition:
- NUM_IN default and TBITS stay in internal_defines.vh alongside `num_spikes / `WBITS / `THRESHOLD.
- Shared package holds the state enum (IDLE, RUN, CLEAR) and the spike-time type logic [TBITS-1:0].
- One natural sub-module, gamma_counter: holds t_now, with start, flush and last-step outputs.
- Per-line compare and OR logic stays in temporal_encoder.

Test Plan (NUM_IN=4, TBITS=3):
- Times {0,3,5,7}, mask 4'b1111 accepted:
  - spikes_out by t_now 0..7 = 0001,0001,0001,0011,0011,0111,0111,1111.
  - Next cycle: spikes_out=0, gamma_done=1 for exactly one cycle.
  - in_ready returns one cycle later.
- Same times, mask 4'b0101: only lines 0 and 2 rise (at t=0 and t=5); lines 1 and 3 stay 0 all window.
- in_valid held continuously with new vectors: acceptances are exactly 10 cycles apart; in_ready is low throughout RUN and CLEAR.
- flush at t_now=4 (spikes 0011): next cycle spikes_out=0, gamma_active=0, no gamma_done, in_ready=1.
- flush and in_valid together in IDLE: no acceptance and state stays IDLE; vector accepted on the next edge after flush drops.
- rst_n pulled low asynchronously at t_now=2: all outputs go to 0 immediately without a clock edge. After release, a new vector starts cleanly at t_now=0.
